// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Line geometry is fixed at 8 x 32-bit words; only the line count is a parameter.
package dcache_pkg;

  localparam int LINE_W         = 256;
  localparam int OFFSET_W       = 5;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Line storage: async read of {valid, dirty, tag, line}; sync word write or full-line fill.
// Only valid/dirty are reset, so a cleared cache never hits on stale tag/data contents.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 23
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fill_we_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              clean_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    line_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clean_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      line_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      line_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: zero-latency hits, miss costs mem latency + 1.
// Stalls the pipeline while not IDLE or on a miss; mem_req_o holds until the one-cycle mem_ack_i.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

  logic [ADDR_W-1:0] acc_addr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word_sel;
  logic              rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              word_we, fill_we, clean;
  logic              unused_addr_bits;

  // During a miss the latched address drives the arrays, so a dropped request cannot redirect the transfer.
  assign acc_addr         = (state_q == IDLE) ? cpu_addr_i : miss_addr_q;
  assign req_tag          = acc_addr[ADDR_W-1 -: TAG_W];
  assign idx              = acc_addr[OFFSET_W +: IDX_W];
  assign word_sel         = acc_addr[2 +: WSEL_W];
  assign unused_addr_bits = ^acc_addr[1:0];
  assign hit              = rd_valid && (rd_tag == req_tag);

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .tag_o       (rd_tag),
    .line_o      (rd_line),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_i      (cpu_data_i),
    .fill_we_i   (fill_we),
    .fill_tag_i  (req_tag),
    .fill_line_i (mem_data_i),
    .clean_i     (clean)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          miss_addr_d = cpu_addr_i;
          state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !hit);
    cpu_data_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    word_we     = 1'b0;
    fill_we     = 1'b0;
    clean       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && hit) begin
          if (cpu_we_i) word_we = 1'b1;
          else          cpu_data_o = rd_line[word_sel*WORD_W +: WORD_W];
        end
      end
      WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {rd_tag, idx, {OFFSET_W{1'b0}}};
        mem_data_o = rd_line;
        clean      = mem_ack_i;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, {OFFSET_W{1'b0}}};
        fill_we    = mem_ack_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hand-computed vectors plus miss/write-back/reset sequences.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  int wb_n     = 0;
  int fetch_n  = 0;

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(16), .ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_data_i  (cpu_wdata),
    .cpu_data_o  (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  // Completed memory transfers, sampled mid-cycle away from the state update.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      if (mem_we) wb_n++;
      else        fetch_n++;
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  initial begin
    logic [255:0] line1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; mem_ack = 0; mem_rdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_data", cpu_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold load miss, refill, then hits on the new line.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    #1;
    chk("t1_stall_on_miss", cpu_stall, 1);
    step();
    chk("t1_alloc_req", mem_req, 1);
    chk("t1_alloc_we", mem_we, 0);
    chk("t1_alloc_addr", mem_addr, 32'h40);
    chk("t1_alloc_stall", cpu_stall, 1);
    line1 = make_line(32'hA000_0000);
    line1[95:64] = 32'h0000_1234;
    mem_rdata = line1; mem_ack = 1;
    step();
    mem_ack = 0; mem_rdata = '0;
    chk("t1_unstall", cpu_stall, 0);
    chk("t1_req_drop", mem_req, 0);
    chk("t1_word0", cpu_rdata, 32'hA000_0000);
    cpu_addr = 32'h48;
    #1;
    chk("t1_word2", cpu_rdata, 32'h0000_1234);

    vecs[0] = '{1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h5C, 32'h0,         1'b0, 1'b1, 32'hA000_0007};
    vecs[3] = '{1'b1, 1'b1, 32'h5C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h5C, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 32'h44, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 1'b1, 32'h0000_1234};
    vecs[7] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 1'b1, 32'hA000_0000};
    for (int i = 0; i < 8; i++) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_mem_req", i), mem_req, 0);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), cpu_rdata, vecs[i].exp_data);
      step();
    end

    // Conflict miss on a dirty line, with the ack held off 10 cycles in each state.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h240;
    #1;
    chk("t3_stall_on_miss", cpu_stall, 1);
    step();
    chk("t3_wb_data_w1", mem_wdata[63:32], 32'hDEAD_BEEF);
    chk("t3_wb_data_w7", mem_wdata[255:224], 32'hCAFE_F00D);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_wb_req_c%0d", i), mem_req, 1);
      chk($sformatf("t4_wb_we_c%0d", i), mem_we, 1);
      chk($sformatf("t4_wb_addr_c%0d", i), mem_addr, 32'h40);
      chk($sformatf("t4_wb_stall_c%0d", i), cpu_stall, 1);
      step();
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_al_req_c%0d", i), mem_req, 1);
      chk($sformatf("t4_al_we_c%0d", i), mem_we, 0);
      chk($sformatf("t4_al_addr_c%0d", i), mem_addr, 32'h240);
      chk($sformatf("t4_al_stall_c%0d", i), cpu_stall, 1);
      step();
    end
    mem_rdata = make_line(32'hB000_0000); mem_ack = 1;
    step();
    mem_ack = 0; mem_rdata = '0;
    chk("t3_unstall", cpu_stall, 0);
    chk("t3_hit_data", cpu_rdata, 32'hB000_0000);
    chk("t4_wb_count", wb_n, 1);
    chk("t4_fetch_count", fetch_n, 2);

    // Clean victim goes straight to ALLOCATE; reset lands mid-transfer.
    cpu_addr = 32'h40;
    #1;
    chk("t5_stall_on_miss", cpu_stall, 1);
    step();
    chk("t5_alloc_we", mem_we, 0);
    chk("t5_alloc_addr", mem_addr, 32'h40);
    rst = 1'b1;
    #1;
    chk("t5_rst_mem_req", mem_req, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    step();
    rst = 1'b0;
    cpu_addr = 32'h240;
    #1;
    chk("t5_prior_hit_misses", cpu_stall, 1);
    step();
    chk("t5_refetch_req", mem_req, 1);
    chk("t5_refetch_we", mem_we, 0);
    chk("t5_refetch_addr", mem_addr, 32'h240);
    mem_rdata = make_line(32'hC000_0000); mem_ack = 1;
    step();
    mem_ack = 0; mem_rdata = '0;
    chk("t5_refill_data", cpu_rdata, 32'hC000_0000);

    // Spurious ack while idle must not touch the arrays.
    cpu_req = 0; mem_rdata = {256{1'b1}}; mem_ack = 1;
    #1;
    chk("t6_req_during_ack", mem_req, 0);
    step();
    mem_ack = 0; mem_rdata = '0;
    chk("t6_req_after_ack", mem_req, 0);
    cpu_req = 1; cpu_addr = 32'h244;
    #1;
    chk("t6_stall", cpu_stall, 0);
    chk("t6_data_intact", cpu_rdata, 32'hC000_0001);
    chk("t6_fetch_count", fetch_n, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
